// File: rtl/lifo_stack.sv
// Single-clock LIFO stack with a registered pop port; pop data appears one cycle after rd_en is sampled.
// Full/empty come from the registered count; pushes when full and pops when empty are silently dropped.
module lifo_stack #(
    parameter int DEPTH      = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_wr,
    input  logic                  wr_en,
    output logic                  lifo_full,
    output logic [DATA_WIDTH-1:0] data_rd,
    input  logic                  rd_en,
    output logic                  lifo_empty
);

    localparam int PTR_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      cnt;
    logic                  do_push;
    logic                  do_pop;
    logic                  do_bypass;

    assign lifo_full  = (cnt == PTR_W'(DEPTH));
    assign lifo_empty = (cnt == '0);

    assign do_bypass = wr_en && rd_en;
    assign do_push   = wr_en && !rd_en && !lifo_full;
    assign do_pop    = rd_en && !wr_en && !lifo_empty;

    // Storage carries no reset; only cnt decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[cnt] <= data_wr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            data_rd <= '0;
        end else if (do_bypass) begin
            data_rd <= data_wr;
        end else if (do_push) begin
            cnt <= cnt + 1'b1;
        end else if (do_pop) begin
            data_rd <= mem[cnt - 1'b1];
            cnt     <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack (DEPTH=12, DATA_WIDTH=8) with hand-computed expectations.
module tb_lifo_stack;

    logic       clk;
    logic       rst;
    logic [7:0] data_wr;
    logic       wr_en;
    logic       rd_en;
    logic       lifo_full;
    logic       lifo_empty;
    logic [7:0] data_rd;

    int vectors;
    int miscompares;

    lifo_stack #(.DEPTH(12), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_wr    (data_wr),
        .wr_en      (wr_en),
        .lifo_full  (lifo_full),
        .data_rd    (data_rd),
        .rd_en      (rd_en),
        .lifo_empty (lifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        wr_en   = w;
        rd_en   = r;
        data_wr = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_wr = 8'h00;
    endtask

    task automatic apply_reset();
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_wr = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (lifo_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b want=1", lifo_empty); end
        vectors++;
        if (lifo_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b want=0", lifo_full); end
        vectors++;
        if (data_rd !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h want=00", data_rd); end
        cycle(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_rd !== 8'h00 || lifo_empty !== 1'b1) begin
            miscompares++; $display("FAIL empty_pop data=%h empty=%b want=00/1", data_rd, lifo_empty);
        end
    endtask

    task automatic test_push_pop_order();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h33; exp_seq[1] = 8'h22; exp_seq[2] = 8'h11;
        cycle(1'b1, 1'b0, 8'h11);
        cycle(1'b1, 1'b0, 8'h22);
        cycle(1'b1, 1'b0, 8'h33);
        vectors++;
        if (lifo_empty !== 1'b0 || data_rd !== 8'h00) begin
            miscompares++; $display("FAIL push3 empty=%b data=%h want=0/00", lifo_empty, data_rd);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            vectors++;
            if (data_rd !== exp_seq[i]) begin
                miscompares++; $display("FAIL order_pop%0d got=%h want=%h", i, data_rd, exp_seq[i]);
            end
        end
        vectors++;
        if (lifo_empty !== 1'b1) begin miscompares++; $display("FAIL order_empty got=%b want=1", lifo_empty); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            vectors++;
            if (lifo_full !== (i == 12)) begin
                miscompares++; $display("FAIL fill_full%0d got=%b want=%b", i, lifo_full, (i == 12));
            end
        end
        cycle(1'b1, 1'b0, 8'hAA);
        vectors++;
        if (lifo_full !== 1'b1 || data_rd !== 8'h11) begin
            miscompares++; $display("FAIL overflow full=%b data=%h want=1/11", lifo_full, data_rd);
        end
        for (int i = 12; i >= 1; i--) begin
            cycle(1'b0, 1'b1, 8'h00);
            vectors++;
            if (data_rd !== 8'(i) || lifo_full !== 1'b0) begin
                miscompares++; $display("FAIL drain%0d data=%h full=%b want=%h/0", i, data_rd, lifo_full, 8'(i));
            end
        end
        vectors++;
        if (lifo_empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got=%b want=1", lifo_empty); end
    endtask

    task automatic test_underflow();
        cycle(1'b1, 1'b0, 8'h5A);
        cycle(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_rd !== 8'h5A || lifo_empty !== 1'b1) begin
            miscompares++; $display("FAIL uflow_first data=%h empty=%b want=5a/1", data_rd, lifo_empty);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            vectors++;
            if (data_rd !== 8'h5A || lifo_empty !== 1'b1 || lifo_full !== 1'b0) begin
                miscompares++; $display("FAIL uflow_extra%0d data=%h empty=%b full=%b want=5a/1/0",
                                        i, data_rd, lifo_empty, lifo_full);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bp [4];
        bp[0] = 8'h10; bp[1] = 8'h20; bp[2] = 8'h30; bp[3] = 8'h40;
        cycle(1'b1, 1'b0, 8'h01);
        cycle(1'b1, 1'b0, 8'h02);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, bp[i]);
            vectors++;
            if (data_rd !== bp[i] || lifo_empty !== 1'b0 || lifo_full !== 1'b0) begin
                miscompares++; $display("FAIL bypass%0d data=%h empty=%b full=%b want=%h/0/0",
                                        i, data_rd, lifo_empty, lifo_full, bp[i]);
            end
        end
        cycle(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_rd !== 8'h02) begin miscompares++; $display("FAIL bypass_pop0 got=%h want=02", data_rd); end
        cycle(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_rd !== 8'h01 || lifo_empty !== 1'b1) begin
            miscompares++; $display("FAIL bypass_pop1 data=%h empty=%b want=01/1", data_rd, lifo_empty);
        end
        cycle(1'b1, 1'b1, 8'h77);
        vectors++;
        if (data_rd !== 8'h77 || lifo_empty !== 1'b1) begin
            miscompares++; $display("FAIL bypass_empty data=%h empty=%b want=77/1", data_rd, lifo_empty);
        end
        for (int i = 1; i <= 12; i++) cycle(1'b1, 1'b0, 8'h80 + 8'(i));
        cycle(1'b1, 1'b1, 8'h99);
        vectors++;
        if (data_rd !== 8'h99 || lifo_full !== 1'b1) begin
            miscompares++; $display("FAIL bypass_full data=%h full=%b want=99/1", data_rd, lifo_full);
        end
        cycle(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_rd !== 8'h8C || lifo_full !== 1'b0) begin
            miscompares++; $display("FAIL after_full_pop data=%h full=%b want=8c/0", data_rd, lifo_full);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'hC0 + 8'(i));
        cycle(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_rd !== 8'hC4 || lifo_empty !== 1'b0) begin
            miscompares++; $display("FAIL pre_arst data=%h empty=%b want=c4/0", data_rd, lifo_empty);
        end
        wr_en   = 1'b1;
        data_wr = 8'hEE;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (lifo_empty !== 1'b1 || data_rd !== 8'h00 || lifo_full !== 1'b0) begin
            miscompares++; $display("FAIL arst_immediate empty=%b data=%h full=%b want=1/00/0",
                                    lifo_empty, data_rd, lifo_full);
        end
        wr_en = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        cycle(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_rd !== 8'h00 || lifo_empty !== 1'b1) begin
            miscompares++; $display("FAIL arst_after_pop data=%h empty=%b want=00/1", data_rd, lifo_empty);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        data_wr     = 8'h00;
        test_reset();
        test_push_pop_order();
        test_fill_overflow();
        test_underflow();
        apply_reset();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Synchronous single-clock LIFO (stack) of DEPTH entries, DATA_WIDTH bits each.
- Push on wr_en, pop on rd_en; pop data is registered.
- Simultaneous push+pop bypasses the write data straight to the read port.
- General-purpose buffer block; full/empty flags let upstream and downstream logic throttle.

Parameters:
- DEPTH, 12, number of storage entries (>=2).
- DATA_WIDTH, 8, width of each entry in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- data_wr  input  DATA_WIDTH  push data, sampled at rising clk when wr_en=1.
- wr_en  input  1  push request.
- lifo_full  output  1  high when entry count == DEPTH.
- data_rd  output  DATA_WIDTH  registered pop data.
- rd_en  input  1  pop request.
- lifo_empty  output  1  high when entry count == 0.

Behaviour:
- State: storage array mem[DEPTH], counter cnt of width $clog2(DEPTH+1), range 0..DEPTH.
- cnt is both the stack pointer and the next free slot. Top of stack is mem[cnt-1].
- lifo_full = (cnt == DEPTH) and lifo_empty = (cnt == 0). Both are decoded from the registered cnt, so they change only after a clock edge.
- Reset (rst=0, async):
  - cnt=0, data_rd=0, lifo_empty=1, lifo_full=0.
  - mem contents are don't-care.
  - Reset asserted mid-operation aborts everything immediately; no pending push or pop survives.
- At each rising clk, with rst=1, exactly one case applies:
  - wr_en=1, rd_en=0, !full: mem[cnt] <= data_wr, cnt <= cnt+1. data_rd holds.
  - wr_en=1, rd_en=0, full: push dropped; cnt, mem and data_rd unchanged. No error output.
  - rd_en=1, wr_en=0, !empty: data_rd <= mem[cnt-1], cnt <= cnt-1. Pop data is visible right after that edge (1-cycle latency from rd_en sampled).
  - rd_en=1, wr_en=0, empty: pop ignored; data_rd holds its previous value and cnt stays 0 (no underflow).
  - rd_en=1, wr_en=1: bypass. data_rd <= data_wr, cnt and mem unchanged. This applies in every state, including empty and full.
  - Neither enabled: hold all state.
- Sustained rd_en pops one entry per cycle in LIFO order. Sustained wr_en pushes one entry per cycle until full.
- No wrap-around: the pointer saturates at 0 and at DEPTH.

Decomposition:
- No shared package needed. The pointer width $clog2(DEPTH+1) is a localparam inside the module.
- Single flat module, no sub-modules. Storage is an inferred register array with a synchronous write port and a registered read.

Test Plan (DEPTH=12, DATA_WIDTH=8):
- Reset:
  - Stimulus: hold rst=0 for 5 cycles, then release.
  - Response: lifo_empty=1, lifo_full=0, data_rd=0.
  - A pop on the empty stack leaves data_rd=0 and lifo_empty=1.
- Push then pop order:
  - Stimulus: push 0x11, 0x22, 0x33 on consecutive cycles, then hold rd_en for 3 cycles.
  - Response: data_rd reads 0x33, 0x22, 0x11 one cycle after each pop edge.
  - lifo_empty=1 after the third pop.
- Fill and overflow:
  - Stimulus: push 1..12, then push 0xAA.
  - Response: lifo_full=1 after the 12th push and 0xAA is dropped.
  - 12 pops then return 12 down to 1; full deasserts after the first pop.
- Underflow:
  - Stimulus: from empty, push 0x5A, then pop 3 times.
  - Response: first pop gives 0x5A. Later pops leave data_rd=0x5A and lifo_empty=1.
- Simultaneous push+pop:
  - Stimulus: with 2 entries (0x01, 0x02) stored, assert both enables for 4 cycles with data_wr = 0x10, 0x20, 0x30, 0x40.
  - Response: data_rd follows 0x10, 0x20, 0x30, 0x40, one cycle behind each edge; cnt stays 2.
  - Subsequent pops return 0x02, 0x01. Repeat the bypass at empty and at full: cnt stays unchanged and the flags don't toggle.
- Async reset mid-stream:
  - Stimulus: push 5 entries, assert rst between clock edges.
  - Response: lifo_empty=1 and data_rd=0 immediately, without waiting for a clock edge.
